inst_fetch_queue: RTL

//  FIFO between I-cache fetch stage and decode stage; decode feeds out_inst to inst decoder.

---
 rtl/inst_fetch_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: FIFO of {pc, inst, adel} between the I-cache fetch stage and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN enables a zero-latency pass-through when the queue is empty.
module inst_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_inst,
    input  logic                         in_adel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_inst,
    output logic                         out_adel,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          adel_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          empty;
    logic          full;
    logic          bypass;
    logic          pop;
    logic          push;
    logic          wr_en;
    logic          rd_stored;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL_COUNT);
        in_ready = !full;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass   = empty && in_valid && !flush;
`else
        bypass   = 1'b0;
`endif
        out_valid = !empty || bypass;
        pop       = out_valid && out_ready;
        push      = in_valid && in_ready && !flush;
        // A bypassed entry consumed in the same cycle never lands in storage.
        wr_en     = push && !(bypass && out_ready);
        rd_stored = pop && !empty && !flush;
    end

    // Head entry when occupied, incoming entry when bypassing, zeros otherwise.
    // Address-error entries present a nop so decode never flags invalid-inst.
    always_comb begin
        out_pc   = 32'h0;
        out_inst = 32'h0;
        out_adel = 1'b0;
        if (!empty) begin
            out_pc   = pc_mem[head];
            out_adel = adel_mem[head];
            out_inst = adel_mem[head] ? 32'h0 : inst_mem[head];
        end else if (bypass) begin
            out_pc   = in_pc;
            out_adel = in_adel;
            out_inst = in_adel ? 32'h0 : in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[tail]   <= in_pc;
            inst_mem[tail] <= in_inst;
            adel_mem[tail] <= in_adel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + PW'(1);
            end
            if (rd_stored) begin
                head <= head + PW'(1);
            end
            case ({wr_en, rd_stored})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
